write_arbiter_rr_n: RTL and testbench

Parametrised round-robin arbiter for the AXI write address channel of the interconnect, generalised from two to `Masters_Num` requesting masters. It sits between the master-side AW inputs and the AW/W routing muxes. It issues a registered, stable grant that is held until the address handshake completes, and optionally until the matching write burst's last beat. Fairness is strict rotation starting after the last served master; an idle master never blocks others.

---
 rtl/write_arbiter_rr_n_pkg.sv | 23 ++
 rtl/rr_priority_pick.sv | 40 ++++
 rtl/write_arbiter_rr_n.sv | 144 ++++++++++++++
 tb/tb_write_arbiter_rr_n.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/write_arbiter_rr_n_pkg.sv
// Shared types and helpers for the round-robin write-address arbiter.
package write_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_AW = 2'd1,
    WAIT_W   = 2'd2
  } write_arb_state_t;

  localparam int unsigned MAX_MASTERS = 16;
  localparam int unsigned MAX_IDX_W   = $clog2(MAX_MASTERS);

  // Binary index of the set bit in a one-hot vector (zero for an all-zero vector).
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational masked priority encoder: first requester strictly after
// last_served_i, scanning upward with wrap-around.
module rr_priority_pick
  import write_arb_pkg::*;
#(
  parameter int unsigned Masters_Num    = 4,
  parameter int unsigned Master_ID_Size = $clog2(Masters_Num)
) (
  input  logic [Masters_Num-1:0]    req_i,
  input  logic [Master_ID_Size-1:0] last_served_i,
  output logic [Master_ID_Size-1:0] win_idx_o,
  output logic [Masters_Num-1:0]    win_onehot_o,
  output logic                      any_req_o
);

  logic        found;
  int unsigned cand;

  // Scan offsets 1..Masters_Num from the last served master; the modulo keeps
  // candidates below Masters_Num, so non-power-of-two sizes never alias.
  always_comb begin
    win_onehot_o = '0;
    found        = 1'b0;
    cand         = 0;
    for (int unsigned k = 1; k <= Masters_Num; k++) begin
      cand = (32'(last_served_i) + k) % Masters_Num;
      if (!found && req_i[Master_ID_Size'(cand)]) begin
        win_onehot_o[Master_ID_Size'(cand)] = 1'b1;
        found = 1'b1;
      end
    end
  end

  // Derive the binary index and the any-request flag from the winner.
  always_comb begin
    win_idx_o = Master_ID_Size'(onehot_to_idx(MAX_MASTERS'(win_onehot_o)));
    any_req_o = |req_i;
  end

endmodule

// File: rtl/write_arbiter_rr_n.sv
// Round-robin AXI write-address arbiter for Masters_Num masters.
// Optional feature macro: WRITE_ARB_W_LOCK_EN (hold grant until W last beat).
module write_arbiter_rr_n
  import write_arb_pkg::*;
#(
  parameter int unsigned Masters_Num    = 4,
  parameter int unsigned Master_ID_Size = $clog2(Masters_Num)
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [Masters_Num-1:0]    M_AXI_awvalid,
  input  logic                      Channel_Granted,
  input  logic                      AW_Handshake,
  input  logic                      W_Last_Handshake,
  output logic                      Channel_Request,
  output logic                      Grant_Valid,
  output logic [Masters_Num-1:0]    Grant_Onehot,
  output logic [Master_ID_Size-1:0] Selected_Master
);

  write_arb_state_t          state_q, state_d;
  logic [Master_ID_Size-1:0] last_served_q, last_served_d;
  logic [Master_ID_Size-1:0] sel_q, sel_d;
  logic [Masters_Num-1:0]    onehot_q, onehot_d;
  logic                      gv_q, gv_d;
`ifdef WRITE_ARB_W_LOCK_EN
  logic                      w_done_q, w_done_d;
`else
  logic                      unused_w_last;
  assign unused_w_last = W_Last_Handshake;
`endif

  logic [Master_ID_Size-1:0] pick_idx;
  logic [Masters_Num-1:0]    pick_oh;
  logic                      pick_any;

  rr_priority_pick #(
    .Masters_Num    (Masters_Num),
    .Master_ID_Size (Master_ID_Size)
  ) u_pick (
    .req_i         (M_AXI_awvalid),
    .last_served_i (last_served_q),
    .win_idx_o     (pick_idx),
    .win_onehot_o  (pick_oh),
    .any_req_o     (pick_any)
  );

  // State and grant registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= IDLE;
      last_served_q <= Master_ID_Size'(Masters_Num - 1);
      sel_q         <= '0;
      onehot_q      <= '0;
      gv_q          <= 1'b0;
`ifdef WRITE_ARB_W_LOCK_EN
      w_done_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      sel_q         <= sel_d;
      onehot_q      <= onehot_d;
      gv_q          <= gv_d;
`ifdef WRITE_ARB_W_LOCK_EN
      w_done_q      <= w_done_d;
`endif
    end
  end

  // Next-state and grant-register update logic.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    sel_d         = sel_q;
    onehot_d      = onehot_q;
    gv_d          = gv_q;
`ifdef WRITE_ARB_W_LOCK_EN
    w_done_d      = w_done_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef WRITE_ARB_W_LOCK_EN
        w_done_d = 1'b0;
`endif
        if (Channel_Granted && pick_any) begin
          state_d  = GRANT_AW;
          sel_d    = pick_idx;
          onehot_d = pick_oh;
          gv_d     = 1'b1;
        end
      end
      GRANT_AW: begin
        if (AW_Handshake) begin
          last_served_d = sel_q;
`ifdef WRITE_ARB_W_LOCK_EN
          // A last beat already seen (or coinciding) closes the burst here.
          if (w_done_q || W_Last_Handshake) begin
            state_d  = IDLE;
            gv_d     = 1'b0;
            onehot_d = '0;
            w_done_d = 1'b0;
          end else begin
            state_d = WAIT_W;
          end
`else
          state_d  = IDLE;
          gv_d     = 1'b0;
          onehot_d = '0;
`endif
        end
`ifdef WRITE_ARB_W_LOCK_EN
        else if (W_Last_Handshake) begin
          w_done_d = 1'b1;
        end
`endif
      end
`ifdef WRITE_ARB_W_LOCK_EN
      WAIT_W: begin
        if (W_Last_Handshake) begin
          state_d  = IDLE;
          gv_d     = 1'b0;
          onehot_d = '0;
          w_done_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d  = IDLE;
        gv_d     = 1'b0;
        onehot_d = '0;
      end
    endcase
  end

  // Outputs: request is combinational only in IDLE; grant outputs are registered.
  always_comb begin
    Channel_Request = (state_q == IDLE) ? (Channel_Granted & pick_any) : 1'b1;
    Grant_Valid     = gv_q;
    Grant_Onehot    = onehot_q;
    Selected_Master = sel_q;
  end

endmodule

// File: tb/tb_write_arbiter_rr_n.sv
// Self-checking bench for write_arbiter_rr_n with Masters_Num=4.
module tb_write_arbiter_rr_n;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = $clog2(N);

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [N-1:0]  M_AXI_awvalid;
  logic          Channel_Granted;
  logic          AW_Handshake;
  logic          W_Last_Handshake;
  logic          Channel_Request;
  logic          Grant_Valid;
  logic [N-1:0]  Grant_Onehot;
  logic [IW-1:0] Selected_Master;

  write_arbiter_rr_n #(
    .Masters_Num    (N),
    .Master_ID_Size (IW)
  ) dut (
    .ACLK             (ACLK),
    .ARESET           (ARESET),
    .M_AXI_awvalid    (M_AXI_awvalid),
    .Channel_Granted  (Channel_Granted),
    .AW_Handshake     (AW_Handshake),
    .W_Last_Handshake (W_Last_Handshake),
    .Channel_Request  (Channel_Request),
    .Grant_Valid      (Grant_Valid),
    .Grant_Onehot     (Grant_Onehot),
    .Selected_Master  (Selected_Master)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level reference: is a grant outstanding, to whom, and what
  // part of the write (address / last beat) has already completed.
  bit m_busy;
  bit m_aw_done;
  bit m_w_seen;
  int m_sel;
  int m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int rr_winner(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= int'(N); k++) begin
      int idx;
      idx = (last + k) % int'(N);
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit lock_mode();
`ifdef WRITE_ARB_W_LOCK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 0; m_aw_done = 0; m_w_seen = 0; m_sel = 0; m_last = int'(N) - 1;
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the reference.
  task automatic cycle(input bit rst, input logic [N-1:0] awv, input bit cg,
                       input bit awh, input bit wl);
    @(negedge ACLK);
    ARESET = rst; M_AXI_awvalid = awv; Channel_Granted = cg;
    AW_Handshake = awh; W_Last_Handshake = wl;
    #1;
    check("chan_req", 32'(Channel_Request), m_busy ? 32'd1 : 32'(cg && (awv != 0)));
    check("grant_valid", 32'(Grant_Valid), 32'(m_busy));
    check("grant_onehot", 32'(Grant_Onehot), m_busy ? (32'd1 << m_sel) : 32'd0);
    check("selected", 32'(Selected_Master), 32'(m_sel));
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (cg && awv != 0) begin
        m_sel = rr_winner(awv, m_last);
        m_busy = 1; m_aw_done = 0; m_w_seen = 0;
      end
    end else if (!m_aw_done) begin
      if (awh) begin
        m_last = m_sel;
        if (!lock_mode() || m_w_seen || wl) m_busy = 0;
        else m_aw_done = 1;
      end else if (wl) begin
        m_w_seen = 1;
      end
    end else if (wl) begin
      m_busy = 0;
    end
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    ARESET = 1; M_AXI_awvalid = '0; Channel_Granted = 0;
    AW_Handshake = 0; W_Last_Handshake = 0;
    repeat (2) @(posedge ACLK);
    model_reset();
    cycle(1, 4'b0000, 0, 0, 0);

    // Full contention with immediate handshakes: strict rotation.
    for (int i = 0; i < 5; i++) begin
      cycle(0, 4'b1111, 1, 0, 0);
      cycle(0, 4'b1111, 1, 1, 1);
      check("rr_order", 32'(Selected_Master), 32'(order[i]));
    end
    cycle(0, 4'b0000, 0, 0, 0);

    // Serve master 3, then lone master 2.
    cycle(0, 4'b1000, 1, 0, 0);
    cycle(0, 4'b1000, 1, 1, 1);
    cycle(0, 4'b0000, 1, 0, 0);
    cycle(0, 4'b0100, 1, 0, 0);
    cycle(0, 4'b0100, 1, 0, 0);
    check("lone_sel", 32'(Selected_Master), 32'd2);
    check("lone_onehot", 32'(Grant_Onehot), 32'b0100);
    cycle(0, 4'b0100, 1, 1, 1);

    // Channel not available: no request, then master 0 wins (last served 2).
    for (int i = 0; i < 5; i++) cycle(0, 4'b0011, 0, 0, 0);
    cycle(0, 4'b0011, 1, 0, 0);
    cycle(0, 4'b0011, 0, 0, 0);
    check("cg_resume_sel", 32'(Selected_Master), 32'd0);
    cycle(0, 4'b0011, 0, 1, 1);

    // Master 1 granted; AW at cycle 3, W last at cycle 7, others requesting.
    cycle(0, 4'b0010, 1, 0, 0);
    for (int c = 1; c <= 8; c++) cycle(0, 4'b1111, 1, c == 3, c == 7);
    // Same with W last at cycle 2, before AW.
    cycle(0, 4'b0000, 1, 0, 0);
    cycle(0, 4'b0010, 1, 0, 0);
    for (int c = 1; c <= 5; c++) cycle(0, 4'b1111, 1, c == 3, c == 2);

    // Reset while holding a grant after the address handshake.
    cycle(0, 4'b0000, 1, 0, 0);
    cycle(0, 4'b0100, 1, 0, 0);
    cycle(0, 4'b0100, 1, 1, 0);
    cycle(1, 4'b1111, 1, 0, 0);
    cycle(0, 4'b1111, 1, 0, 0);
    cycle(0, 4'b1111, 1, 0, 0);
    check("post_reset_sel", 32'(Selected_Master), 32'd0);

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) < 2, N'($urandom), $urandom_range(3) != 0,
            $urandom_range(9) < 3, $urandom_range(9) < 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
